// File: rtl/riscv_core_div_seq.sv
// -----------------------------------------------------------------------------
// riscv_core_div_seq
//
// Iterative RISC-V M-extension divider: DIV/DIVU/REM/REMU and the RV64 word
// forms (DIVW/DIVUW/REMW/REMUW). One quotient bit per cycle, restoring
// datapath operating on operand magnitudes, followed by a sign-fix cycle.
// Divide-by-zero and signed overflow finish on a short path.
//
// Optional feature macro: DIV_FAST_SMALL_EN
//   When defined, a non-special op with |A| < |B| also finishes on the
//   short path (quotient 0, remainder = dividend).
//
// Ports:
//   i_div_clk          clock, rising edge
//   i_div_rstn         asynchronous active-low reset
//   i_div_start        request, sampled only in IDLE
//   i_div_kill         flush; returns to IDLE, no done, results untouched
//   i_div_srcA/srcB    dividend / divisor (XLEN)
//   i_div_control      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_div_isword       W form (low XLEN/2 bits, result sign-extended)
//   o_div_busy         high in every state except IDLE
//   o_div_done         one-cycle completion pulse
//   o_div_result       result, held from done to the next done
//   o_div_div_by_zero  divisor was zero
//   o_div_overflow     signed overflow (most-negative / -1)
//   o_div_dbg_state    current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: a request is accepted on a rising edge where i_div_start=1,
// i_div_kill=0 and the FSM is in IDLE (o_div_busy=0); operands are captured
// on that edge only. Completion is the single cycle with o_div_done=1, and
// o_div_result/flags are valid from then until the next completion. Starts
// while busy are dropped, not queued.
// -----------------------------------------------------------------------------
module riscv_core_div_seq #(
  parameter int XLEN = 64
) (
  input  logic            i_div_clk,
  input  logic            i_div_rstn,
  input  logic            i_div_start,
  input  logic            i_div_kill,
  input  logic [XLEN-1:0] i_div_srcA,
  input  logic [XLEN-1:0] i_div_srcB,
  input  logic [1:0]      i_div_control,
  input  logic            i_div_isword,
  output logic            o_div_busy,
  output logic            o_div_done,
  output logic [XLEN-1:0] o_div_result,
  output logic            o_div_div_by_zero,
  output logic            o_div_overflow,
  output logic [1:0]      o_div_dbg_state
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  // Most-negative dividend as it appears after sign extension to XLEN.
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rem_op_q, rem_op_d;
  logic            isword_q, isword_d;
  logic            negq_q, negq_d;     // quotient must be negated
  logic            nega_q, nega_d;     // remainder takes negative sign
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] quo_q, quo_d;       // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v,
                                               input logic            w);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Operand decode from the live inputs; only used on the accepting edge.
  logic            op_signed, op_rem;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            a_neg, b_neg, is_dbz, is_ovf;

  always_comb begin
    op_signed = ~i_div_control[0];
    op_rem    = i_div_control[1];
    if (i_div_isword) begin
      a_ext = op_signed ? {{HALF{i_div_srcA[HALF-1]}}, i_div_srcA[HALF-1:0]}
                        : {{HALF{1'b0}}, i_div_srcA[HALF-1:0]};
      b_ext = op_signed ? {{HALF{i_div_srcB[HALF-1]}}, i_div_srcB[HALF-1:0]}
                        : {{HALF{1'b0}}, i_div_srcB[HALF-1:0]};
    end else begin
      a_ext = i_div_srcA;
      b_ext = i_div_srcB;
    end
    a_neg  = op_signed & a_ext[XLEN-1];
    b_neg  = op_signed & b_ext[XLEN-1];
    a_mag  = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag  = b_neg ? (~b_ext + 1'b1) : b_ext;
    is_dbz = (b_ext == '0);
    is_ovf = op_signed && (a_ext == (i_div_isword ? MIN_W : MIN_D)) &&
             (b_ext == {XLEN{1'b1}});
  end

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits XLEN+1 bits and the top bit of the trial
  // difference is a clean borrow.
  logic [XLEN:0]   rem_shift, trial;
  logic            trial_ok;
  logic [XLEN-1:0] quo_fix, rem_fix, res_fix;

  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    trial_ok  = ~trial[XLEN];
    quo_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = nega_q ? (~rem_q + 1'b1) : rem_q;
    res_fix   = word_ext(rem_op_q ? rem_fix : quo_fix, isword_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_op_d  = rem_op_q;
    isword_d  = isword_q;
    negq_d    = negq_q;
    nega_d    = nega_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    if (i_div_kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_div_start) begin
            rem_op_d = op_rem;
            isword_d = i_div_isword;
            if (is_dbz) begin
              state_d  = S_DONE;
              result_d = word_ext(op_rem ? a_ext : {XLEN{1'b1}}, i_div_isword);
              dbz_d    = 1'b1;
              ovf_d    = 1'b0;
            end else if (is_ovf) begin
              state_d  = S_DONE;
              result_d = word_ext(op_rem ? '0 : a_ext, i_div_isword);
              dbz_d    = 1'b0;
              ovf_d    = 1'b1;
`ifdef DIV_FAST_SMALL_EN
            end else if (a_mag < b_mag) begin
              state_d  = S_DONE;
              result_d = word_ext(op_rem ? a_ext : '0, i_div_isword);
              dbz_d    = 1'b0;
              ovf_d    = 1'b0;
`endif
            end else begin
              state_d   = S_CALC;
              cnt_d     = i_div_isword ? CW'(HALF - 1) : CW'(XLEN - 1);
              divisor_d = b_mag;
              rem_d     = '0;
              // Word dividends are pre-aligned so their MSB shifts out first.
              quo_d     = i_div_isword ? (a_mag << HALF) : a_mag;
              negq_d    = a_neg ^ b_neg;
              nega_d    = a_neg;
            end
          end
        end
        S_CALC: begin
          rem_d = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], trial_ok};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          state_d  = S_DONE;
          result_d = res_fix;
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_div_clk or negedge i_div_rstn) begin
    if (!i_div_rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_op_q  <= 1'b0;
      isword_q  <= 1'b0;
      negq_q    <= 1'b0;
      nega_q    <= 1'b0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_op_q  <= rem_op_d;
      isword_q  <= isword_d;
      negq_q    <= negq_d;
      nega_q    <= nega_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_div_busy        = (state_q != S_IDLE);
  assign o_div_done        = (state_q == S_DONE);
  assign o_div_result      = result_q;
  assign o_div_div_by_zero = dbz_q;
  assign o_div_overflow    = ovf_q;
  assign o_div_dbg_state   = state_q;

endmodule

// File: tb/tb_riscv_core_div_seq.sv
// -----------------------------------------------------------------------------
// tb_riscv_core_div_seq
//
// Directed bench for riscv_core_div_seq (XLEN = 64): a table of operations
// with hand-computed results, flags and latencies, plus sequences for kill,
// ignored starts and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_riscv_core_div_seq;

  localparam int XLEN     = 64;
  localparam int MAX_WAIT = 200;
`ifdef DIV_FAST_SMALL_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 66;
`endif

  localparam logic [1:0] C_DIV  = 2'b00;
  localparam logic [1:0] C_DIVU = 2'b01;
  localparam logic [1:0] C_REM  = 2'b10;
  localparam logic [1:0] C_REMU = 2'b11;

  // ---------------- clock / reset ----------------
  logic            clk;
  logic            rst_n;
  logic            start;
  logic            kill;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [1:0]      ctrl;
  logic            isword;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            dbz;
  logic            ovf;
  logic [1:0]      dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  riscv_core_div_seq #(.XLEN(XLEN)) dut (
    .i_div_clk         (clk),
    .i_div_rstn        (rst_n),
    .i_div_start       (start),
    .i_div_kill        (kill),
    .i_div_srcA        (src_a),
    .i_div_srcB        (src_b),
    .i_div_control     (ctrl),
    .i_div_isword      (isword),
    .o_div_busy        (busy),
    .o_div_done        (done),
    .o_div_result      (result),
    .o_div_div_by_zero (dbz),
    .o_div_overflow    (ovf),
    .o_div_dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check64(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge with the DUT idle. Returns the number of
  // edges from the sampling edge up to the one after which done is high.
  task automatic run_op(input logic [1:0] c, input logic w,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output int lat);
    ctrl   = c;
    isword = w;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    src_a  = $urandom_range(0, 65535);   // operands must not matter now
    src_b  = $urandom_range(0, 65535);
    lat    = 1;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    string           name;
    logic [1:0]      ctrl;
    logic            isword;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp_res;
    logic            exp_dbz;
    logic            exp_ovf;
    int              exp_lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    int              lat;
    int              n_done;
    logic [XLEN-1:0] exp;
    logic [XLEN-1:0] last_res;
    logic            last_dbz;
    logic            last_ovf;

    vecs[0]  = '{"div_m7_2",      C_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 66};
    vecs[1]  = '{"remw_m7_2",     C_REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 34};
    vecs[2]  = '{"divu_5_0",      C_DIVU, 1'b0, 64'd5,                   64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1};
    vecs[3]  = '{"remu_5_0",      C_REMU, 1'b0, 64'd5,                   64'd0,                  64'd5,                   1'b1, 1'b0, 1};
    vecs[4]  = '{"divw_ovf",      C_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1};
    vecs[5]  = '{"divu_3_10",     C_DIVU, 1'b0, 64'd3,                   64'd10,                 64'd0,                   1'b0, 1'b0, SMALL_LAT};
    vecs[6]  = '{"remu_3_10",     C_REMU, 1'b0, 64'd3,                   64'd10,                 64'd3,                   1'b0, 1'b0, SMALL_LAT};
    vecs[7]  = '{"rem_m7_2",      C_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 66};
    vecs[8]  = '{"div_7_m2",      C_DIV,  1'b0, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 66};
    vecs[9]  = '{"div_min_m1",    C_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1};
    vecs[10] = '{"rem_min_m1",    C_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1'b0, 1'b1, 1};
    vecs[11] = '{"divuw_sext",    C_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 34};
    vecs[12] = '{"remuw_5",       C_REMU, 1'b1, 64'h0000_0000_8000_0005, 64'h10,                 64'd5,                   1'b0, 1'b0, 34};
    vecs[13] = '{"divu_max_max",  C_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   1'b0, 1'b0, 66};
    vecs[14] = '{"rem_m5_0",      C_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0, 1};
    vecs[15] = '{"divw_lo_zero",  C_DIV,  1'b1, 64'd7,                   64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1};
    vecs[16] = '{"remw_10_m3",    C_REM,  1'b1, 64'hAAAA_0000_0000_000A, 64'h0000_0000_FFFF_FFFD, 64'd1,                   1'b0, 1'b0, 34};
    vecs[17] = '{"divw_hi_junk",  C_DIV,  1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 64'd14,                  1'b0, 1'b0, 34};

    rst_n  = 1'b0;
    start  = 1'b0;
    kill   = 1'b0;
    src_a  = '0;
    src_b  = '0;
    ctrl   = 2'b00;
    isword = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_busy",  int'(busy), 0);
    check_int("rst_done",  int'(done), 0);
    check64("rst_result", result, '0);
    check_int("rst_dbz",   int'(dbz), 0);
    check_int("rst_ovf",   int'(ovf), 0);
    check_int("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table ----
    last_res = '0;
    last_dbz = 1'b0;
    last_ovf = 1'b0;
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vecs[i].exp_res);
      run_op(vecs[i].ctrl, vecs[i].isword, vecs[i].a, vecs[i].b, lat);
      exp = exp_q.pop_front();
      check_int({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      check64({vecs[i].name, "_res"}, result, exp);
      check_int({vecs[i].name, "_dbz"}, int'(dbz), int'(vecs[i].exp_dbz));
      check_int({vecs[i].name, "_ovf"}, int'(ovf), int'(vecs[i].exp_ovf));
      @(posedge clk); #1;
      check_int({vecs[i].name, "_done_pulse"}, int'(done), 0);
      check_int({vecs[i].name, "_idle_after"}, int'(busy), 0);
      check64({vecs[i].name, "_res_hold"}, result, exp);
      last_res = exp;
      last_dbz = vecs[i].exp_dbz;
      last_ovf = vecs[i].exp_ovf;
    end

    // ---- kill during CALC ----
    ctrl = C_DIV; isword = 1'b0; src_a = 64'd1000; src_b = 64'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_int("kill_pre_busy", int'(busy), 1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_int("kill_busy", int'(busy), 0);
    check_int("kill_done", int'(done), 0);
    check64("kill_res", result, last_res);
    n_done = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    check_int("kill_no_done", n_done, 0);

    // ---- kill and start together in IDLE: kill wins ----
    ctrl = C_DIVU; src_a = 64'd100; src_b = 64'd0;
    start = 1'b1;
    kill  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kill  = 1'b0;
    check_int("killstart_busy", int'(busy), 0);
    check_int("killstart_done", int'(done), 0);
    check_int("killstart_dbz", int'(dbz), int'(last_dbz));
    check_int("killstart_ovf", int'(ovf), int'(last_ovf));
    @(posedge clk); #1;
    check_int("killstart_done2", int'(done), 0);

    // ---- DIVU 100/7 with an ignored start and operand churn mid-CALC ----
    exp_q.push_back(64'd14);
    ctrl = C_DIVU; isword = 1'b0; src_a = 64'd100; src_b = 64'd7;
    start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      if (lat == 5) begin
        start = 1'b1;
        ctrl  = C_DIV;
        src_a = 64'd1;
        src_b = 64'd0;
      end else begin
        start = 1'b0;
        src_a = $urandom_range(0, 1000);
        src_b = $urandom_range(0, 1000);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    check_int("reissue_lat", lat, 66);
    check64("reissue_res", result, exp);
    check_int("reissue_dbz", int'(dbz), 0);
    check_int("reissue_ovf", int'(ovf), 0);
    @(posedge clk); #1;

    // ---- reset asserted mid-operation ----
    run_op(C_DIVU, 1'b0, 64'd5, 64'd0, lat);
    check_int("pre_rst_dbz", int'(dbz), 1);
    @(posedge clk); #1;
    ctrl = C_DIVU; isword = 1'b0; src_a = 64'hFFFF_FFFF_FFFF_FFFF; src_b = 64'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_int("midrst_busy",  int'(busy), 0);
    check_int("midrst_done",  int'(done), 0);
    check64("midrst_result", result, '0);
    check_int("midrst_dbz",   int'(dbz), 0);
    check_int("midrst_state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- recovery after reset ----
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    run_op(C_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
    exp = exp_q.pop_front();
    check_int("recover_lat", lat, 66);
    check64("recover_res", result, exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_core_div_seq.md
# riscv_core_div_seq

Parametrised iterative integer divider for the M-extension execute stage, covering DIV/DIVU/REM/REMU and the RV64 word forms DIVW/DIVUW/REMW/REMUW. It computes the quotient or remainder with a one-bit-per-cycle restoring datapath and applies RISC-V sign correction and word sign-extension. It handles divide-by-zero and signed overflow on a short path, and signals completion with a start/done handshake to the execute-stage stall logic.

## Interface
- XLEN, 64, datapath width; must be even and ≥ 8. Word width is XLEN/2.
- i_div_clk  input  1  clock; all state changes on the rising edge.
- i_div_rstn  input  1  reset, asynchronous, active-low.
- i_div_start  input  1  request; sampled only in IDLE.
- i_div_kill  input  1  pipeline flush; aborts any operation in flight.
- i_div_srcA  input  XLEN  dividend.
- i_div_srcB  input  XLEN  divisor.
- i_div_control  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_div_isword  input  1  1 selects the W form (operands are the low XLEN/2 bits).
- o_div_busy  output  1  high in every state except IDLE.
- o_div_done  output  1  one-cycle completion pulse.
- o_div_result  output  XLEN  final result.
- o_div_div_by_zero  output  1  divisor was zero.
- o_div_overflow  output  1  signed overflow (most-negative ÷ −1).

## Operation
- States: IDLE, CALC, FIX, DONE.
- On the start edge, the block latches the opcode and isword, and computes W (XLEN or XLEN/2).
  - Operands are sign-extended for signed ops and zero-extended for unsigned ops, then converted to magnitudes |A| and |B|.
- Short path, IDLE → DONE, applies when:
  - B == 0: quotient = all ones; remainder = dividend. div_by_zero = 1.
  - Signed op with A == −2^(W−1) and B == −1: quotient = A; remainder = 0. overflow = 1.
- Long path, IDLE → CALC:
  - A counter loads W−1.
  - Each CALC cycle shifts one dividend bit into the partial remainder, performs a trial subtract of |B|, and sets the quotient bit.
  - CALC → FIX when the counter reaches 0.
- FIX:
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign (signed ops only).
  - FIX → DONE.
- DONE:
  - Registers o_div_result and the flags, and pulses o_div_done.
  - DONE → IDLE unconditionally.
- Word forms: the result's bit XLEN/2−1 is sign-extended into bits XLEN−1:XLEN/2. This applies to DIVUW/REMUW too, and to the short-path results.
- o_div_result and the flags hold their value from done until the next done. Flags are 0 on long-path results.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and the counter resets to 0.
- Latency, measured from the edge that samples i_div_start in IDLE to the cycle in which o_div_done = 1:
  - short path: 1 cycle;
  - long path: W+2 cycles (66 for XLEN = 64, 34 for word ops).
- i_div_start while busy is ignored; no queueing.
- A new start may be accepted in the cycle after done, since DONE returns to IDLE.
- i_div_kill in any state:
  - next state is IDLE, with no done pulse;
  - result and flag registers are unchanged.
- i_div_kill and i_div_start together in IDLE: kill wins and the start is dropped.
- Inputs are sampled only on the start edge. Operand changes during CALC have no effect.
- Reset asserted mid-operation: immediate return to IDLE, and all outputs go to 0.

## Configuration
- DIV_FAST_SMALL_EN defined:
  - A non-special long-path op with |A| < |B| goes IDLE → DONE with a 1-cycle latency.
  - Quotient = 0; remainder = dividend with its original sign, word-extended where applicable.
- DIV_FAST_SMALL_EN undefined: such ops take the full W+2 cycles and produce identical values.

## Test plan
- DIV, XLEN = 64, A = −7, B = 2 → o_div_result = 0xFFFF_FFFF_FFFF_FFFD, done exactly 66 cycles after start, both flags 0.
- REMW, A = 0x1234_5678_FFFF_FFF9, B = 2 → result 0xFFFF_FFFF_FFFF_FFFF (−1), done at 34 cycles.
- DIVU, A = 5, B = 0 → result 0xFFFF_FFFF_FFFF_FFFF, div_by_zero = 1, done at 1 cycle. REMU with the same operands → result 5.
- DIVW, A = 0x0000_0000_8000_0000, B = 0x0000_0000_FFFF_FFFF → result 0xFFFF_FFFF_8000_0000, overflow = 1, done at 1 cycle.
- Kill and re-issue:
  - DIV started, i_div_kill at CALC cycle 10 → no done, busy low the next cycle.
  - DIVU 100/7 is then accepted → result 14 at 66 cycles.
  - A start pulsed mid-CALC is ignored.
- DIVU, A = 3, B = 10 → result 0, done at 1 cycle with DIV_FAST_SMALL_EN and at 66 cycles without it.
